decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue_if.sv | 89 ++++++++
 rtl/decode_queue.sv | 232 +++++++++++++++++++++++
 tb/tb_decode_queue.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// RV32I control-word package and decode queue handshake interface.
// Opcode constants and the control word shared by decode and execute.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef enum logic [2:0] {
    alu_add, alu_sll, alu_sra, alu_sub,
    alu_xor, alu_srl, alu_or, alu_and
  } alu_ops;

  typedef enum logic [3:0] {
    rf_alu_out, rf_br_en, rf_u_imm, rf_lw,
    rf_pc_plus4, rf_lb, rf_lbu, rf_lh, rf_lhu
  } rf_sel_t;

  typedef enum logic [2:0] {
    a2_i_imm, a2_u_imm, a2_b_imm,
    a2_s_imm, a2_j_imm, a2_rs2
  } alu2_sel_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
    alu_ops      aluop;
    logic [2:0]  cmpop;
    logic        alumux1_sel;
    alu2_sel_t   alumux2_sel;
    logic        cmpmux_sel;
    rf_sel_t     regfilemux_sel;
    logic        load_regfile;
    logic        mem_read;
    logic        mem_write;
    logic        allow_br;
    logic        allow_jmp;
    logic [3:0]  mem_byte_enable;
  } rv32i_control_word;

endpackage

interface decode_queue_if
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_instr;
  logic [31:0]            in_pc;
  logic                   out_valid;
  logic                   out_ready;
  rv32i_control_word      out_ctrl;
  logic                   out_illegal;
  logic                   out_muldiv;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_ctrl,
    input  out_illegal, out_muldiv, count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_ctrl,
    output out_illegal, out_muldiv, count
  );

endinterface

// File: rtl/decode_queue.sv
// Decode queue: decodes RV32I words on push, holds DEPTH entries.
// Define RV32M_EN to accept M-extension op_reg encodings.
module decode_queue
  import rv32i_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] IDLE_NOP = 32'h00000013
) (
  input logic           clk,
  input logic           rst,
  decode_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    rv32i_control_word ctrl;
    logic              illegal;
`ifdef RV32M_EN
    logic              muldiv;
`endif
  } entry_t;

  function automatic entry_t decode(
    input logic [31:0] ir,
    input logic [31:0] pc
  );
    entry_t     e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ill;
    logic       md;
    e  = '0;
    f3 = ir[14:12];
    f7 = ir[31:25];
    ill = 1'b0;
    md  = 1'b0;
    e.ctrl.pc     = pc;
    e.ctrl.opcode = ir[6:0];
    e.ctrl.funct3 = f3;
    e.ctrl.funct7 = f7;
    e.ctrl.rd     = ir[11:7];
    e.ctrl.rs1    = ir[19:15];
    e.ctrl.rs2    = ir[24:20];
    e.ctrl.i_imm  = {{21{ir[31]}}, ir[30:20]};
    e.ctrl.s_imm  = {{21{ir[31]}}, ir[30:25], ir[11:7]};
    e.ctrl.b_imm  = {{20{ir[31]}}, ir[7], ir[30:25],
                     ir[11:8], 1'b0};
    e.ctrl.u_imm  = {ir[31:12], 12'h000};
    e.ctrl.j_imm  = {{12{ir[31]}}, ir[19:12], ir[20],
                     ir[30:21], 1'b0};
    e.ctrl.aluop          = alu_add;
    e.ctrl.cmpop          = f3;
    e.ctrl.alumux2_sel    = a2_i_imm;
    e.ctrl.regfilemux_sel = rf_alu_out;
    unique case (1'b1)
      (ir[6:0] == OP_LUI): begin
        e.ctrl.load_regfile   = 1'b1;
        e.ctrl.regfilemux_sel = rf_u_imm;
      end
      (ir[6:0] == OP_AUIPC): begin
        e.ctrl.load_regfile = 1'b1;
        e.ctrl.alumux1_sel  = 1'b1;
        e.ctrl.alumux2_sel  = a2_u_imm;
      end
      (ir[6:0] == OP_JAL): begin
        e.ctrl.load_regfile   = 1'b1;
        e.ctrl.allow_jmp      = 1'b1;
        e.ctrl.alumux1_sel    = 1'b1;
        e.ctrl.alumux2_sel    = a2_j_imm;
        e.ctrl.regfilemux_sel = rf_pc_plus4;
      end
      (ir[6:0] == OP_JALR): begin
        e.ctrl.load_regfile   = 1'b1;
        e.ctrl.allow_jmp      = 1'b1;
        e.ctrl.regfilemux_sel = rf_pc_plus4;
      end
      (ir[6:0] == OP_BR): begin
        e.ctrl.allow_br    = 1'b1;
        e.ctrl.alumux1_sel = 1'b1;
        e.ctrl.alumux2_sel = a2_b_imm;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      (ir[6:0] == OP_LOAD): begin
        e.ctrl.load_regfile = 1'b1;
        e.ctrl.mem_read     = 1'b1;
        unique case (f3)
          3'b000:  e.ctrl.regfilemux_sel = rf_lb;
          3'b001:  e.ctrl.regfilemux_sel = rf_lh;
          3'b010:  e.ctrl.regfilemux_sel = rf_lw;
          3'b100:  e.ctrl.regfilemux_sel = rf_lbu;
          3'b101:  e.ctrl.regfilemux_sel = rf_lhu;
          default: ill = 1'b1;
        endcase
      end
      (ir[6:0] == OP_STORE): begin
        e.ctrl.mem_write   = 1'b1;
        e.ctrl.alumux2_sel = a2_s_imm;
        unique case (f3)
          3'b000:  e.ctrl.mem_byte_enable = 4'b0001;
          3'b001:  e.ctrl.mem_byte_enable = 4'b0011;
          3'b010:  e.ctrl.mem_byte_enable = 4'b1111;
          default: ill = 1'b1;
        endcase
      end
      (ir[6:0] == OP_IMM): begin
        e.ctrl.load_regfile = 1'b1;
        e.ctrl.cmpmux_sel   = 1'b1;
        unique case (f3)
          3'b010: begin
            e.ctrl.cmpop          = 3'b100;
            e.ctrl.regfilemux_sel = rf_br_en;
          end
          3'b011: begin
            e.ctrl.cmpop          = 3'b110;
            e.ctrl.regfilemux_sel = rf_br_en;
          end
          3'b001: begin
            e.ctrl.aluop = alu_sll;
            ill = (f7 != 7'h00);
          end
          3'b101: begin
            e.ctrl.aluop = f7[5] ? alu_sra : alu_srl;
            ill = (f7 != 7'h00) && (f7 != 7'h20);
          end
          default: e.ctrl.aluop = alu_ops'(f3);
        endcase
      end
      (ir[6:0] == OP_REG): begin
        e.ctrl.load_regfile = 1'b1;
        e.ctrl.alumux2_sel  = a2_rs2;
`ifdef RV32M_EN
        md = (f7 == 7'b0000001);
`endif
        if (!md) begin
          // sub/sra are the only funct7=0100000 encodings
          ill = ((f7 != 7'h00) && (f7 != 7'h20)) ||
                ((f7 == 7'h20) && (f3 != 3'b000) &&
                 (f3 != 3'b101));
          unique case (f3)
            3'b000: e.ctrl.aluop = f7[5] ? alu_sub : alu_add;
            3'b101: e.ctrl.aluop = f7[5] ? alu_sra : alu_srl;
            3'b010: begin
              e.ctrl.cmpop          = 3'b100;
              e.ctrl.regfilemux_sel = rf_br_en;
            end
            3'b011: begin
              e.ctrl.cmpop          = 3'b110;
              e.ctrl.regfilemux_sel = rf_br_en;
            end
            default: e.ctrl.aluop = alu_ops'(f3);
          endcase
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      e.ctrl.load_regfile = 1'b0;
      e.ctrl.mem_read     = 1'b0;
      e.ctrl.mem_write    = 1'b0;
      e.ctrl.allow_br     = 1'b0;
      e.ctrl.allow_jmp    = 1'b0;
      md = 1'b0;
    end
    e.illegal = ill;
`ifdef RV32M_EN
    e.muldiv = md;
`endif
    return e;
  endfunction

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count_q;
  entry_t        mem [DEPTH];
  entry_t        dec_in;
  entry_t        idle;
  entry_t        head_e;
  logic          push;
  logic          pop;

  assign bus.in_ready  = (count_q < FULL);
  assign bus.out_valid = (count_q != '0);
  assign bus.count     = count_q;

  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

  assign dec_in = decode(bus.in_instr, bus.in_pc);

  always_comb begin
    idle = decode(IDLE_NOP, 32'h0);
    idle.ctrl.load_regfile = 1'b0;
    idle.illegal = 1'b0;
`ifdef RV32M_EN
    idle.muldiv = 1'b0;
`endif
  end

  assign head_e = bus.out_valid ? mem[head] : idle;

  assign bus.out_ctrl    = head_e.ctrl;
  assign bus.out_illegal = head_e.illegal;
`ifdef RV32M_EN
  assign bus.out_muldiv  = head_e.muldiv;
`else
  assign bus.out_muldiv  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= dec_in;
  end

endmodule

// File: tb/tb_decode_queue.sv
// Randomized bench for decode_queue against a queue-based reference.
// Reference decode follows the opcode/funct legality rules directly.
module tb_decode_queue;
  import rv32i_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(DEPTH)) bus ();

  decode_queue #(
    .DEPTH(DEPTH),
    .IDLE_NOP(32'h00000013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } item_t;

  typedef struct {
    logic       ill;
    logic       md;
    logic       lr;
    logic       mr;
    logic       mw;
    logic       br;
    logic       jmp;
    logic [3:0] mbe;
  } exp_t;

  item_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_dec(input logic [31:0] ins);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    e = '{default: '0};
    if (op == 7'h37 || op == 7'h17) begin
      e.lr = 1;
    end else if (op == 7'h6f || op == 7'h67) begin
      e.lr = 1;
      e.jmp = 1;
    end else if (op == 7'h63) begin
      e.br = 1;
      e.ill = (f3 == 2 || f3 == 3);
    end else if (op == 7'h03) begin
      e.lr = 1;
      e.mr = 1;
      e.ill = (f3 == 3 || f3 == 6 || f3 == 7);
    end else if (op == 7'h23) begin
      e.mw = 1;
      e.mbe = (f3 == 0) ? 4'h1 : (f3 == 1) ? 4'h3 : 4'hf;
      e.ill = (f3 > 2);
    end else if (op == 7'h13) begin
      e.lr = 1;
      e.ill = (f3 == 1 && f7 != 0) ||
              (f3 == 5 && f7 != 0 && f7 != 7'h20);
    end else if (op == 7'h33) begin
      e.lr = 1;
      if (f7 == 7'h01) begin
`ifdef RV32M_EN
        e.md = 1;
`else
        e.ill = 1;
`endif
      end else if (f7 != 0 && f7 != 7'h20) begin
        e.ill = 1;
      end else if (f7 == 7'h20 && f3 != 0 && f3 != 5) begin
        e.ill = 1;
      end
    end else begin
      e.ill = 1;
    end
    if (e.ill) begin
      e.lr = 0; e.mr = 0; e.mw = 0;
      e.br = 0; e.jmp = 0; e.md = 0;
    end
    return e;
  endfunction

  task automatic check_all();
    exp_t  e;
    item_t h;
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
    if (q.size() == 0) begin
      chk("idle_opcode", 32'(bus.out_ctrl.opcode), 32'h13);
      chk("idle_rd", 32'(bus.out_ctrl.rd), 0);
      chk("idle_lr", 32'(bus.out_ctrl.load_regfile), 0);
      chk("idle_ill", 32'(bus.out_illegal), 0);
      chk("idle_md", 32'(bus.out_muldiv), 0);
    end else begin
      h = q[0];
      e = ref_dec(h.ins);
      chk("pc", bus.out_ctrl.pc, h.pc);
      chk("illegal", 32'(bus.out_illegal), 32'(e.ill));
      chk("muldiv", 32'(bus.out_muldiv), 32'(e.md));
      chk("load_regfile", 32'(bus.out_ctrl.load_regfile),
          32'(e.lr));
      chk("mem_read", 32'(bus.out_ctrl.mem_read), 32'(e.mr));
      chk("mem_write", 32'(bus.out_ctrl.mem_write), 32'(e.mw));
      chk("allow_br", 32'(bus.out_ctrl.allow_br), 32'(e.br));
      chk("allow_jmp", 32'(bus.out_ctrl.allow_jmp), 32'(e.jmp));
      chk("rd", 32'(bus.out_ctrl.rd), 32'(h.ins[11:7]));
      chk("funct3", 32'(bus.out_ctrl.funct3), 32'(h.ins[14:12]));
      chk("i_imm", bus.out_ctrl.i_imm,
          32'($signed(h.ins[31:20])));
      if (e.mw)
        chk("mbe", 32'(bus.out_ctrl.mem_byte_enable),
            32'(e.mbe));
    end
  endtask

  task automatic step(input logic f, input logic v,
                      input logic r, input logic [31:0] ins,
                      input logic [31:0] pc);
    logic push_ok;
    logic pop_ok;
    bus.flush     = f;
    bus.in_valid  = v;
    bus.out_ready = r;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    push_ok = v && (q.size() < DEPTH) && !f;
    pop_ok  = (q.size() > 0) && r && !f;
    @(posedge clk);
    if (f) begin
      q.delete();
    end else begin
      if (pop_ok) q.delete(0);
      if (push_ok) q.push_back('{ins, pc});
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 9))
      0: w[6:0] = OP_LUI;
      1: w[6:0] = OP_AUIPC;
      2: w[6:0] = OP_JAL;
      3: w[6:0] = OP_JALR;
      4: w[6:0] = OP_BR;
      5: w[6:0] = OP_LOAD;
      6: w[6:0] = OP_STORE;
      7: w[6:0] = OP_IMM;
      8: w[6:0] = OP_REG;
      default: w[6:0] = 7'($urandom());
    endcase
    if (w[6:0] == OP_REG || w[6:0] == OP_IMM) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    bus.flush = 0; bus.in_valid = 0; bus.out_ready = 0;
    bus.in_instr = 0; bus.in_pc = 0;
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // addi x1,x0,5 visible the following cycle
    step(0, 1, 0, 32'h00500093, 32'h100);
    chk("addi_rd", 32'(bus.out_ctrl.rd), 1);
    chk("addi_imm", bus.out_ctrl.i_imm, 5);
    chk("addi_lr", 32'(bus.out_ctrl.load_regfile), 1);
    step(0, 0, 1, 0, 0);

    // fill past full, then drain in order across the wrap
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, 32'h00000093 | (i << 20), 32'h200 + 4 * i);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", bus.out_ctrl.pc, 32'h200 + 4 * i);
      step(0, 0, 1, 0, 0);
    end

    // simultaneous push and pop at count 2
    step(0, 1, 0, 32'h00100093, 32'h300);
    step(0, 1, 0, 32'h00200093, 32'h304);
    step(0, 1, 1, 32'h00300093, 32'h308);
    chk("pp_count", 32'(bus.count), 2);
    chk("pp_pc", bus.out_ctrl.pc, 32'h304);

    // flush at count 3 with a push in flight
    step(0, 1, 0, 32'h00400093, 32'h30c);
    step(1, 1, 1, 32'h00900093, 32'h999);
    chk("flush_count", 32'(bus.count), 0);
    step(0, 0, 1, 0, 0);

    // mul x0,x1,x2
    step(0, 1, 0, 32'h02208033, 32'h400);
`ifdef RV32M_EN
    chk("mul_md", 32'(bus.out_muldiv), 1);
    chk("mul_ill", 32'(bus.out_illegal), 0);
`else
    chk("mul_ill", 32'(bus.out_illegal), 1);
    chk("mul_lr", 32'(bus.out_ctrl.load_regfile), 0);
`endif
    step(0, 0, 1, 0, 0);

    // sh then an unknown opcode, then async reset mid-stream
    step(0, 1, 0, 32'h00209223, 32'h500);
    step(0, 1, 0, 32'h0000007f, 32'h504);
    chk("sh_mbe", 32'(bus.out_ctrl.mem_byte_enable), 32'h3);
    chk("sh_mw", 32'(bus.out_ctrl.mem_write), 1);
    step(0, 1, 1, 32'h00500093, 32'h508);
    chk("bad_ill", 32'(bus.out_illegal), 1);
    chk("bad_mw", 32'(bus.out_ctrl.mem_write), 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_valid", 32'(bus.out_valid), 0);
    chk("arst_ready", 32'(bus.in_ready), 1);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    check_all();
    step(0, 1, 1, 32'h00700093, 32'h600);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 1) == 1),
           rand_instr(), 32'h1000 + 4 * i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
